// File: rtl/apb_master_nslv_if.sv
// Request/response port plus APB bus of the multi-slave APB master.
// The master modport is the bridge's view; the slave modport is the environment's view.
interface apb_master_nslv_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_SLV = 4
);
  logic                        req_valid;
  logic                        req_ready;
  logic                        req_write;
  logic [ADDR_W-1:0]           req_addr;
  logic [DATA_W-1:0]           req_wdata;
  logic                        rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;
  logic                        rsp_err;
  logic [ADDR_W-1:0]           PADDR;
  logic [DATA_W-1:0]           PWDATA;
  logic                        PWRITE;
  logic [NUM_SLV-1:0]          PSEL;
  logic                        PENABLE;
  logic [NUM_SLV*DATA_W-1:0]   PRDATA;
  logic [NUM_SLV-1:0]          PREADY;
  logic [NUM_SLV-1:0]          PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface

// File: rtl/apb_master_nslv.sv
// APB master bridging a valid/ready request port to NUM_SLV APB slaves, with
// top-address-bit slave decode, PSLVERR/decode-error reporting and wait-state timeout.
module apb_master_nslv #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              PCLK,
  input  logic              PRESERn,
  apb_master_nslv_if.master bus
);

  localparam int unsigned SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t              r_state;
  logic [SEL_W-1:0]    r_idx;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic                r_pwrite;
  logic [NUM_SLV-1:0]  r_psel;
  logic                r_penable;
  logic [7:0]          r_cnt;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_rsp_rdata;

  logic [SEL_W-1:0]    w_req_idx;
  logic [NUM_SLV-1:0]  w_req_onehot;
  logic                w_dec_err;
  logic                w_accept;
  logic                w_sel_ready;
  logic                w_sel_err;
  logic [DATA_W-1:0]   w_sel_rdata;
  logic                w_timeout;

  assign w_req_idx = bus.req_addr[ADDR_W-1 -: SEL_W];
  assign w_accept  = bus.req_valid && (r_state == S_IDLE);
  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

  // Loop-based decode keeps out-of-range indices (non-power-of-two NUM_SLV) as a flag, not an index.
  always_comb begin
    w_req_onehot = '0;
    w_dec_err    = 1'b1;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (32'(w_req_idx) == i) begin
        w_req_onehot[i] = 1'b1;
        w_dec_err       = 1'b0;
      end
    end
  end

  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (32'(r_idx) == i) begin
        w_sel_ready = bus.PREADY[i];
        w_sel_err   = bus.PSLVERR[i];
        w_sel_rdata = bus.PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESERn) begin
    if (!PRESERn) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pwrite    <= 1'b0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idx    <= w_req_idx;
            r_paddr  <= bus.req_addr;
            r_pwrite <= bus.req_write;
            if (bus.req_write) begin
              r_pwdata <= bus.req_wdata;
            end
            if (w_dec_err) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              r_psel  <= w_req_onehot;
              r_state <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_sel_ready) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_sel_err;
            r_rsp_rdata <= (!r_pwrite && !w_sel_err) ? w_sel_rdata : '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_state     <= S_IDLE;
          end else if (w_timeout) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_psel    <= '0;
          r_penable <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;

endmodule

// File: tb/tb_apb_master_nslv.sv
// Scoreboard bench for apb_master_nslv: one 4-slave instance (TIMEOUT=4) and one
// 3-slave instance for decode errors; a negedge monitor pops expected responses.
module tb_apb_master_nslv;

  logic PCLK = 1'b0;
  logic PRESERn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_master_nslv_if #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(4)) ifa ();
  apb_master_nslv_if #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(3)) ifb ();

  apb_master_nslv #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(4), .TIMEOUT(4)) u_dut_a (
    .PCLK(PCLK), .PRESERn(PRESERn), .bus(ifa.master));
  apb_master_nslv #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(3), .TIMEOUT(15)) u_dut_b (
    .PCLK(PCLK), .PRESERn(PRESERn), .bus(ifb.master));

  typedef struct {
    logic       err;
    logic [7:0] rdata;
    logic [3:0] psel;
    int         pcyc;
    int         ecyc;
    logic [7:0] addr;
    logic       wr;
    logic [7:0] wdata;
    int         lat;
  } exp_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  exp_t sb0[$];
  exp_t sb1[$];
  int   st0[$];
  int   st1[$];
  int         pcnt[2];
  int         ecnt[2];
  logic [3:0] lpsel[2];
  logic [7:0] cap_addr[2];
  logic [7:0] cap_wd[2];
  logic       unstable[2];

  // Slave models: ACCESS-cycle counter, per-slave wait states / never-ready / error / read data.
  int         wcnt_a = 0;
  int         wcnt_b = 0;
  int         wait_a[4] = '{0, 0, 3, 0};
  logic [3:0] nev_a = 4'b0010;
  logic [3:0] err_a = 4'b1000;
  logic [7:0] rd_a[4] = '{8'h11, 8'h22, 8'h3C, 8'hEE};
  logic [7:0] rd_b[3] = '{8'h01, 8'h5A, 8'h03};

  always @(posedge PCLK) begin
    cyc    <= cyc + 1;
    wcnt_a <= ifa.PENABLE ? wcnt_a + 1 : 0;
    wcnt_b <= ifb.PENABLE ? wcnt_b + 1 : 0;
  end

  always_comb begin
    ifa.PREADY  = '0;
    ifa.PSLVERR = '0;
    ifa.PRDATA  = '0;
    for (int i = 0; i < 4; i++) begin
      ifa.PREADY[i]        = !nev_a[i] && (wcnt_a >= wait_a[i]);
      ifa.PSLVERR[i]       = err_a[i];
      ifa.PRDATA[i*8 +: 8] = rd_a[i];
    end
  end

  always_comb begin
    ifb.PREADY  = '0;
    ifb.PSLVERR = '0;
    ifb.PRDATA  = '0;
    for (int i = 0; i < 3; i++) begin
      ifb.PREADY[i]        = (wcnt_b >= 0);
      ifb.PRDATA[i*8 +: 8] = rd_b[i];
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(logic err, logic [7:0] rd, logic [3:0] psel, int pc, int ec,
                              logic [7:0] addr, logic wr, logic [7:0] wd, int lat);
    exp_t e;
    e.err = err; e.rdata = rd; e.psel = psel; e.pcyc = pc; e.ecyc = ec;
    e.addr = addr; e.wr = wr; e.wdata = wd; e.lat = lat;
    return e;
  endfunction

  task automatic clear_mon();
    for (int d = 0; d < 2; d++) begin
      pcnt[d] = 0; ecnt[d] = 0; lpsel[d] = '0; unstable[d] = 1'b0;
      cap_addr[d] = '0; cap_wd[d] = '0;
    end
    st0.delete();
    st1.delete();
  endtask

  task automatic observe(input int d, input logic [3:0] psel, input logic pen,
                         input logic [7:0] paddr, input logic [7:0] pwdata, input logic rv,
                         input logic rerr, input logic [7:0] rdata, input logic acc);
    exp_t e;
    int   st;
    if (!PRESERn) return;
    if (psel != 4'b0) begin
      if (pcnt[d] == 0) begin
        cap_addr[d] = paddr;
        cap_wd[d]   = pwdata;
      end else if (paddr != cap_addr[d] || pwdata != cap_wd[d]) begin
        unstable[d] = 1'b1;
      end
      pcnt[d]++;
      lpsel[d] = psel;
    end
    if (pen) ecnt[d]++;
    if (rv) begin
      if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1 expected none", d);
      end else begin
        if (d == 0) begin e = sb0.pop_front(); st = (st0.size() > 0) ? st0.pop_front() : -100; end
        else        begin e = sb1.pop_front(); st = (st1.size() > 0) ? st1.pop_front() : -100; end
        chk($sformatf("rsp_err[d%0d a%0h]", d, e.addr), int'(rerr), int'(e.err));
        chk($sformatf("rsp_rdata[d%0d a%0h]", d, e.addr), int'(rdata), int'(e.rdata));
        chk($sformatf("psel[d%0d a%0h]", d, e.addr), int'(lpsel[d]), int'(e.psel));
        chk($sformatf("psel_cycles[d%0d a%0h]", d, e.addr), pcnt[d], e.pcyc);
        chk($sformatf("penable_cycles[d%0d a%0h]", d, e.addr), ecnt[d], e.ecyc);
        chk($sformatf("latency[d%0d a%0h]", d, e.addr), cyc - st, e.lat);
        if (e.pcyc > 0) begin
          chk($sformatf("paddr[d%0d a%0h]", d, e.addr), int'(cap_addr[d]), int'(e.addr));
          chk($sformatf("apb_stable[d%0d a%0h]", d, e.addr), int'(unstable[d]), 0);
        end
        if (e.wr) chk($sformatf("pwdata[d%0d a%0h]", d, e.addr), int'(cap_wd[d]), int'(e.wdata));
      end
      pcnt[d] = 0; ecnt[d] = 0; lpsel[d] = '0; unstable[d] = 1'b0;
    end
    if (acc) begin
      if (d == 0) st0.push_back(cyc);
      else        st1.push_back(cyc);
    end
  endtask

  always @(negedge PCLK) begin
    observe(0, ifa.PSEL, ifa.PENABLE, ifa.PADDR, ifa.PWDATA, ifa.rsp_valid, ifa.rsp_err,
            ifa.rsp_rdata, ifa.req_valid && ifa.req_ready);
    observe(1, {1'b0, ifb.PSEL}, ifb.PENABLE, ifb.PADDR, ifb.PWDATA, ifb.rsp_valid,
            ifb.rsp_err, ifb.rsp_rdata, ifb.req_valid && ifb.req_ready);
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input int d, input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                       input exp_t e, input bit push, output int acc_cyc);
    logic rdy;
    int   n;
    if (push) begin
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
    if (d == 0) begin
      ifa.req_valid = 1'b1; ifa.req_write = wr; ifa.req_addr = addr; ifa.req_wdata = wd;
    end else begin
      ifb.req_valid = 1'b1; ifb.req_write = wr; ifb.req_addr = addr; ifb.req_wdata = wd;
    end
    n = 0;
    rdy = (d == 0) ? ifa.req_ready : ifb.req_ready;
    while (!rdy && n < 50) begin
      @(posedge PCLK); #1;
      rdy = (d == 0) ? ifa.req_ready : ifb.req_ready;
      n++;
    end
    if (!rdy) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout dut%0d addr 0x%0h: got req_ready=0 expected 1", d, addr);
    end
    @(posedge PCLK); #1;
    acc_cyc = cyc;
    ifa.req_valid = 1'b0;
    ifb.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 40) begin
      @(posedge PCLK); #1;
      n++;
    end
    if (sb0.size() != 0 || sb1.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout: got %0d pending expected 0", sb0.size() + sb1.size());
    end
    @(posedge PCLK); #1;
  endtask

  int a1, a2;

  initial begin
    ifa.req_valid = 1'b0; ifa.req_write = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0;
    ifb.req_valid = 1'b0; ifb.req_write = 1'b0; ifb.req_addr = '0; ifb.req_wdata = '0;
    clear_mon();
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_psel", int'(ifa.PSEL), 0);
    chk("rst_penable", int'(ifa.PENABLE), 0);
    chk("rst_rsp_valid", int'(ifa.rsp_valid), 0);
    chk("rst_rsp_rdata", int'(ifa.rsp_rdata), 0);
    chk("rst_paddr", int'(ifa.PADDR), 0);
    chk("rst_pwdata", int'(ifa.PWDATA), 0);
    PRESERn = 1'b1;
    @(posedge PCLK); #1;
    chk("rst_req_ready", int'(ifa.req_ready), 1);

    // zero-wait write to slave0 (slave3 error/ready lines must be ignored)
    issue(0, 1'b1, 8'h12, 8'hA5, mk(1'b0, 8'h00, 4'b0001, 2, 1, 8'h12, 1'b1, 8'hA5, 3), 1, a1);
    wait_idle();
    // read slave2 with three wait states; PWDATA keeps last write value
    issue(0, 1'b0, 8'h85, 8'hFF, mk(1'b0, 8'h3C, 4'b0100, 5, 4, 8'h85, 1'b0, 8'h00, 6), 1, a1);
    wait_idle();
    chk("pwdata_hold_on_read", int'(ifa.PWDATA), 8'hA5);
    chk("paddr_hold_idle", int'(ifa.PADDR), 8'h85);
    // slave error on write and on read (read data forced to zero)
    issue(0, 1'b1, 8'hC0, 8'h5C, mk(1'b1, 8'h00, 4'b1000, 2, 1, 8'hC0, 1'b1, 8'h5C, 3), 1, a1);
    wait_idle();
    issue(0, 1'b0, 8'hC9, 8'h00, mk(1'b1, 8'h00, 4'b1000, 2, 1, 8'hC9, 1'b0, 8'h00, 3), 1, a1);
    wait_idle();
    // timeout on slave1: PENABLE high for exactly TIMEOUT=4 cycles
    issue(0, 1'b0, 8'h47, 8'h00, mk(1'b1, 8'h00, 4'b0010, 5, 4, 8'h47, 1'b0, 8'h00, 6), 1, a1);
    wait_idle();
    // back-to-back: second accepted in the first's response cycle
    issue(0, 1'b1, 8'h20, 8'h77, mk(1'b0, 8'h00, 4'b0001, 2, 1, 8'h20, 1'b1, 8'h77, 3), 1, a1);
    issue(0, 1'b0, 8'h30, 8'h00, mk(1'b0, 8'h11, 4'b0001, 2, 1, 8'h30, 1'b0, 8'h00, 3), 1, a2);
    chk("b2b_spacing", a2 - a1, 3);
    wait_idle();
    // decode error on 3-slave instance, then a normal read there
    issue(1, 1'b0, 8'hC4, 8'h00, mk(1'b1, 8'h00, 4'b0000, 0, 0, 8'hC4, 1'b0, 8'h00, 1), 1, a1);
    wait_idle();
    chk("dec_err_no_psel", int'(ifb.PSEL), 0);
    issue(1, 1'b0, 8'h40, 8'h00, mk(1'b0, 8'h5A, 4'b0010, 2, 1, 8'h40, 1'b0, 8'h00, 3), 1, a1);
    wait_idle();

    // reset in the middle of ACCESS: outputs clear immediately, no response
    issue(0, 1'b0, 8'h47, 8'h00, mk(1'b0, 8'h00, 4'b0000, 0, 0, 8'h00, 1'b0, 8'h00, 0), 0, a1);
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    chk("mid_access_penable", int'(ifa.PENABLE), 1);
    #2 PRESERn = 1'b0;
    #1;
    chk("midrst_psel", int'(ifa.PSEL), 0);
    chk("midrst_penable", int'(ifa.PENABLE), 0);
    chk("midrst_rsp_valid", int'(ifa.rsp_valid), 0);
    clear_mon();
    repeat (2) @(posedge PCLK);
    #1;
    chk("midrst_paddr", int'(ifa.PADDR), 0);
    chk("midrst_pwrite", int'(ifa.PWRITE), 0);
    PRESERn = 1'b1;
    @(posedge PCLK); #1;
    chk("post_rst_req_ready", int'(ifa.req_ready), 1);
    issue(0, 1'b1, 8'h12, 8'hA5, mk(1'b0, 8'h00, 4'b0001, 2, 1, 8'h12, 1'b1, 8'hA5, 3), 1, a1);
    wait_idle();
    repeat (5) @(posedge PCLK);
    #1;
    chk("sb_drain", sb0.size() + sb1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_master_nslv.md
Name: apb_master_nslv

Overview:
- Parametrised APB master bridging a simple valid/ready request port to an APB bus with NUM_SLV slaves.
- Decodes the slave from the top address bits and drives the matching PSEL.
- Adds over the single-slave master: configurable address/data width, fully registered APB outputs, PSLVERR reporting, decode-error reporting, and a wait-state timeout.
- Sits between the system-side controller and the peripheral APB slaves.

Parameters:
- ADDR_W, 8: address width; must be greater than SEL_W.
- DATA_W, 8: data width.
- NUM_SLV, 4: number of slaves, 2..16. SEL_W = clog2(NUM_SLV).
- TIMEOUT, 15: maximum ACCESS cycles without PREADY before abort, 1..255.

Ports:
- PCLK  in  1  clock.
- PRESERn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  slave error, decode error, or timeout.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  NUM_SLV  one-hot slave select.
- PENABLE  out  1  APB enable.
- PRDATA  in  NUM_SLV*DATA_W  slave read data, slave i at bits [i*DATA_W +: DATA_W].
- PREADY  in  NUM_SLV  per-slave ready.
- PSLVERR  in  NUM_SLV  per-slave error.

Behaviour:
- Reset: one clock, PCLK. PRESERn is asynchronous active-low. On reset:
  - state = IDLE
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA = 0
  - rsp_valid, rsp_err, rsp_rdata = 0
  - timeout counter = 0
  - req_ready = 1 once reset is released
- Output timing: all APB and rsp outputs are registered. req_ready is a combinational decode of state: high only in IDLE.
- Slave index: idx = req_addr[ADDR_W-1 -: SEL_W], captured on accept.
- IDLE:
  - rsp_valid is low unless completing; it is a single-cycle pulse.
  - On req_valid && req_ready: latch idx, drive PADDR = req_addr and PWRITE = req_write. Drive PWDATA = req_wdata on writes only; reads leave PWDATA unchanged.
  - If idx >= NUM_SLV: no PSEL is asserted. Next cycle: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, state stays IDLE.
  - Otherwise go to SETUP with PSEL[idx] = 1 and PENABLE = 0.
- SETUP: lasts exactly one cycle. Then ACCESS with PENABLE = 1 and the counter cleared.
- ACCESS, sampled each edge:
  - PREADY[idx] = 1: capture rsp_rdata = PRDATA slice (reads; 0 on writes or when PSLVERR[idx] = 1) and rsp_err = PSLVERR[idx]. Pulse rsp_valid, clear PSEL and PENABLE, return to IDLE.
  - PREADY[idx] = 0 and counter == TIMEOUT-1: abort. Clear PSEL and PENABLE, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, return to IDLE.
  - Otherwise increment the counter and hold all APB outputs.
- Stability: PADDR, PWRITE and PWDATA stay stable from SETUP through ACCESS completion and hold their values in IDLE.
- Latency: accept edge N; SETUP cycle N+1; ACCESS cycle N+2. With zero wait states, rsp_valid and req_ready are both high in cycle N+3, so a new request is accepted in the same cycle as the response. Minimum throughput is 3 cycles per transfer.
- Non-selected slaves: PREADY, PSLVERR and PRDATA of non-selected slaves are ignored.
- Request signals are don't-care outside IDLE.
- No backpressure on rsp; rsp_valid is never held.
- Reset mid-transfer: outputs return immediately to reset values and no response is issued.

Test Plan:
- Zero-wait write. NUM_SLV=4, write addr 0x12 data 0xA5, slave0 PREADY tied 1 -> PSEL=0001 for 2 cycles; PENABLE high in cycle 2; rsp_valid in cycle 3 with rsp_err=0 and rsp_rdata=0.
- Read with waits. Read addr 0x85 (idx 2), slave2 holds PREADY low 3 ACCESS cycles then returns PRDATA=0x3C -> PSEL=0100 for 5 cycles; rsp_rdata=0x3C; rsp_err=0; PADDR stays 0x85 throughout.
- Slave error. Write addr 0xC0, slave3 returns PREADY=1 with PSLVERR=1 -> rsp_valid with rsp_err=1.
- Timeout. TIMEOUT=4, slave1 never ready -> PENABLE high exactly 4 cycles, then PSEL=0, rsp_err=1, rsp_rdata=0.
- Decode error. NUM_SLV=3, read addr 0xC4 (idx 3) -> PSEL stays 000; rsp_valid with rsp_err=1 one cycle after accept.
- Back-to-back and reset. Queue two zero-wait requests -> second accepted in the response cycle of the first, 3 cycles apart. Separately, assert PRESERn low mid-ACCESS -> PSEL, PENABLE and rsp_valid drop to 0 immediately, with no response.
